rvp_wb_checker: RTL and testbench

Synthesizable run controller and writeback checker for riscv_pipeline: replaces hand-timed testbench sequencing with a parametrised, self-checking harness. Holds the DUT in reset, runs until pc_out reaches a programmable halt PC, then drains and pulses dump. It also compares every architectural writeback against a preloaded expected table and reports pass/fail, the first mismatch and timeout. Sits beside the DUT in benches and FPGA bring-up tops.

---
 rtl/rvp_tb_pkg.sv | 30 +++
 rtl/rvp_exp_table.sv | 44 ++++
 rtl/rvp_wb_checker.sv | 223 ++++++++++++++++++++++
 tb/tb_rvp_wb_checker.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvp_tb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rvp_tb_pkg
// Description : Shared types for the riscv_pipeline run controller and
//               writeback checker: controller state encoding and the default
//               expected-writeback entry layout {rd, data}.
// Revision    : 1.0 - initial release
// ============================================================================
package rvp_tb_pkg;

    localparam int c_def_xlen   = 32;
    localparam int c_def_reg_aw = 5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HOLD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DUMP  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // One expected architectural writeback at the default widths.
    typedef struct packed {
        logic [c_def_reg_aw-1:0] rd;
        logic [c_def_xlen-1:0]   data;
    } wb_entry_t;

endpackage : rvp_tb_pkg
`default_nettype wire

// File: rtl/rvp_exp_table.sv
`default_nettype none
// ============================================================================
// Module      : rvp_exp_table
// Description : Expected-writeback storage, DEPTH entries of {rd, data}.
//               One synchronous write port, one asynchronous read port so
//               the checker can compare in the same cycle a writeback shows.
// Ports       : clk              - clock
//               i_we/i_waddr     - write strobe / entry index
//               i_wrd/i_wdata    - entry contents to write
//               i_raddr          - read index
//               o_rrd/o_rdata    - entry contents at i_raddr (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module rvp_exp_table #(
    parameter int DEPTH  = 16,
    parameter int RD_W   = 5,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [RD_W-1:0]          i_wrd,
    input  logic [DATA_W-1:0]        i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [RD_W-1:0]          o_rrd,
    output logic [DATA_W-1:0]        o_rdata
);

    // Contents are deliberately not reset so a table survives a run abort.
    logic [RD_W-1:0]   r_rd   [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_rd[i_waddr]   <= i_wrd;
            r_data[i_waddr] <= i_wdata;
        end
    end

    assign o_rrd   = r_rd[i_raddr];
    assign o_rdata = r_data[i_raddr];

endmodule : rvp_exp_table
`default_nettype wire

// File: rtl/rvp_wb_checker.sv
`default_nettype none
// ============================================================================
// Module      : rvp_wb_checker
// Description : Run controller and writeback checker for riscv_pipeline.
//               Holds the DUT in reset, runs it until pc_out >= halt_pc,
//               drains, pulses dump, and compares every non-x0 writeback
//               against a preloaded expected table.
// Ports       : clk, reset          - clock, synchronous active-high reset
//               start, halt_pc      - begin run (IDLE/DONE), halt threshold
//               exp_we/waddr/a/d    - expected table load (IDLE only)
//               exp_count           - valid entries, sampled on start
//               dut_reset, dump     - DUT reset, one-cycle dump strobe
//               pc_out, wb_e/a/d    - DUT PC and writeback port
//               done, pass          - run finished, result
//               err_idx/a/d         - first failing writeback
//               err_timeout         - run aborted by TIMEOUT
//               cycle_count         - cycles spent in RUN+DRAIN
// Revision    : 1.0 - initial release
// ============================================================================
module rvp_wb_checker #(
    parameter int XLEN         = 32,
    parameter int REG_AW       = 5,
    parameter int EXP_DEPTH    = 16,
    parameter int RESET_CYCLES = 2,
    parameter int DRAIN_CYCLES = 4,
    parameter int TIMEOUT      = 1024
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [XLEN-1:0]              halt_pc,
    input  logic                         exp_we,
    input  logic [$clog2(EXP_DEPTH)-1:0] exp_waddr,
    input  logic [REG_AW-1:0]            exp_a,
    input  logic [XLEN-1:0]              exp_d,
    input  logic [$clog2(EXP_DEPTH):0]   exp_count,
    output logic                         dut_reset,
    input  logic [XLEN-1:0]              pc_out,
    input  logic                         wb_e,
    input  logic [REG_AW-1:0]            wb_a,
    input  logic [XLEN-1:0]              wb_d,
    output logic                         dump,
    output logic                         done,
    output logic                         pass,
    output logic [$clog2(EXP_DEPTH):0]   err_idx,
    output logic [REG_AW-1:0]            err_a,
    output logic [XLEN-1:0]              err_d,
    output logic                         err_timeout,
    output logic [31:0]                  cycle_count
);

    import rvp_tb_pkg::*;

    localparam int              c_aw         = $clog2(EXP_DEPTH);
    localparam int              c_pw         = c_aw + 1;
    localparam logic [c_pw-1:0] c_depth      = c_pw'(EXP_DEPTH);
    localparam logic [31:0]     c_hold_last  = 32'(RESET_CYCLES - 1);
    localparam logic [31:0]     c_run_last   = 32'(TIMEOUT - 1);
    localparam logic [31:0]     c_drain_last = (DRAIN_CYCLES > 0) ? 32'(DRAIN_CYCLES - 1) : 32'd0;

    state_t             r_state;
    state_t             w_next;
    logic [31:0]        r_cnt;
    logic [c_pw-1:0]    r_count;
    logic [c_pw-1:0]    r_ptr;
    logic [XLEN-1:0]    r_halt_pc;
    logic               r_err_seen;
    logic [c_pw-1:0]    r_err_idx;
    logic [REG_AW-1:0]  r_err_a;
    logic [XLEN-1:0]    r_err_d;
    logic               r_err_timeout;
    logic [31:0]        r_cycle_count;

    logic               w_active;
    logic               w_start_acc;
    logic               w_cmp;
    logic               w_bad;
    logic               w_enter_done;
    logic [REG_AW-1:0]  w_tab_rd;
    logic [XLEN-1:0]    w_tab_data;
    logic [c_pw-1:0]    w_ptr_nx;
    logic               w_err_seen_nx;
    logic [c_pw-1:0]    w_err_idx_nx;
    logic [REG_AW-1:0]  w_err_a_nx;
    logic [XLEN-1:0]    w_err_d_nx;

    rvp_exp_table #(
        .DEPTH  (EXP_DEPTH),
        .RD_W   (REG_AW),
        .DATA_W (XLEN)
    ) u_table (
        .clk     (clk),
        .i_we    (exp_we && (r_state == ST_IDLE)),
        .i_waddr (exp_waddr),
        .i_wrd   (exp_a),
        .i_wdata (exp_d),
        .i_raddr (r_ptr[c_aw-1:0]),
        .o_rrd   (w_tab_rd),
        .o_rdata (w_tab_data)
    );

    assign w_active    = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign w_start_acc = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:  if (start) w_next = ST_HOLD;
            ST_HOLD:  if (r_cnt == c_hold_last) w_next = ST_RUN;
            ST_RUN: begin
                // Halt takes priority over a timeout landing in the same cycle.
                if (pc_out >= r_halt_pc)      w_next = ST_DRAIN;
                else if (r_cnt == c_run_last) w_next = ST_DONE;
            end
            ST_DRAIN: if (r_cnt == c_drain_last) w_next = ST_DUMP;
            ST_DUMP:  w_next = ST_DONE;
            ST_DONE:  if (start) w_next = ST_HOLD;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        dut_reset = (r_state == ST_IDLE) || (r_state == ST_HOLD);
        dump      = (r_state == ST_DUMP);
        done      = (r_state == ST_DONE);
        pass      = (r_state == ST_DONE) && !r_err_seen && !r_err_timeout;
    end

    // Per-state cycle counter, restarts on every state change.
    always_ff @(posedge clk) begin
        if (reset || (w_next != r_state)) begin
            r_cnt <= 32'd0;
        end else begin
            r_cnt <= r_cnt + 32'd1;
        end
    end

    // ------------------------------------------------------------ compare
    assign w_cmp        = w_active && wb_e && (wb_a != '0);
    assign w_bad        = (r_ptr < r_count) ? ((wb_a != w_tab_rd) || (wb_d != w_tab_data)) : 1'b1;
    assign w_enter_done = (r_state != ST_DONE) && (w_next == ST_DONE);

    always_comb begin
        w_ptr_nx      = r_ptr;
        w_err_seen_nx = r_err_seen;
        w_err_idx_nx  = r_err_idx;
        w_err_a_nx    = r_err_a;
        w_err_d_nx    = r_err_d;
        if (w_cmp) begin
            if (r_ptr != c_depth) begin
                w_ptr_nx = r_ptr + c_pw'(1);
            end
            if (w_bad && !r_err_seen) begin
                w_err_seen_nx = 1'b1;
                w_err_idx_nx  = r_ptr;
                w_err_a_nx    = wb_a;
                w_err_d_nx    = wb_d;
            end
        end
        // Missing writebacks are judged on the pointer after this cycle's
        // compare, since the timeout cycle can still carry a writeback.
        if (w_enter_done && !w_err_seen_nx && (w_ptr_nx != r_count)) begin
            w_err_seen_nx = 1'b1;
            w_err_idx_nx  = w_ptr_nx;
            w_err_a_nx    = '0;
            w_err_d_nx    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count       <= '0;
            r_halt_pc     <= '0;
            r_ptr         <= '0;
            r_err_seen    <= 1'b0;
            r_err_idx     <= '0;
            r_err_a       <= '0;
            r_err_d       <= '0;
            r_err_timeout <= 1'b0;
            r_cycle_count <= 32'd0;
        end else if (w_start_acc) begin
            r_count       <= (exp_count > c_depth) ? c_depth : exp_count;
            r_halt_pc     <= halt_pc;
            r_ptr         <= '0;
            r_err_seen    <= 1'b0;
            r_err_idx     <= '0;
            r_err_a       <= '0;
            r_err_d       <= '0;
            r_err_timeout <= 1'b0;
            r_cycle_count <= 32'd0;
        end else begin
            r_ptr      <= w_ptr_nx;
            r_err_seen <= w_err_seen_nx;
            r_err_idx  <= w_err_idx_nx;
            r_err_a    <= w_err_a_nx;
            r_err_d    <= w_err_d_nx;
            if (w_active) begin
                r_cycle_count <= r_cycle_count + 32'd1;
            end
            // RUN can only reach DONE directly through the timeout.
            if ((r_state == ST_RUN) && (w_next == ST_DONE)) begin
                r_err_timeout <= 1'b1;
            end
        end
    end

    assign err_idx     = r_err_idx;
    assign err_a       = r_err_a;
    assign err_d       = r_err_d;
    assign err_timeout = r_err_timeout;
    assign cycle_count = r_cycle_count;

endmodule : rvp_wb_checker
`default_nettype wire

// File: tb/tb_rvp_wb_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_rvp_wb_checker
// Description : Self-checking bench for rvp_wb_checker. A CPU stand-in
//               drives pc_out and writebacks; a reference model predicts the
//               run outcome from the rules on plain lists, and a monitor
//               compares the outcome whenever done rises.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rvp_wb_checker;
    import rvp_tb_pkg::*;

    localparam int XLEN         = 32;
    localparam int REG_AW       = 5;
    localparam int EXP_DEPTH    = 16;
    localparam int RESET_CYCLES = 2;
    localparam int DRAIN_CYCLES = 4;
    localparam int TIMEOUT      = 50;
    localparam int AW           = $clog2(EXP_DEPTH);

    logic              clk = 1'b0;
    logic              reset, start, exp_we, wb_e;
    logic [XLEN-1:0]   halt_pc, exp_d, pc_out, wb_d;
    logic [AW-1:0]     exp_waddr;
    logic [REG_AW-1:0] exp_a, wb_a;
    logic [AW:0]       exp_count;
    logic              dut_reset, dump, done, pass, err_timeout;
    logic [AW:0]       err_idx;
    logic [REG_AW-1:0] err_a;
    logic [XLEN-1:0]   err_d;
    logic [31:0]       cycle_count;

    always #5 clk = ~clk;

    rvp_wb_checker #(
        .XLEN(XLEN), .REG_AW(REG_AW), .EXP_DEPTH(EXP_DEPTH),
        .RESET_CYCLES(RESET_CYCLES), .DRAIN_CYCLES(DRAIN_CYCLES), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .halt_pc(halt_pc),
        .exp_we(exp_we), .exp_waddr(exp_waddr), .exp_a(exp_a), .exp_d(exp_d),
        .exp_count(exp_count), .dut_reset(dut_reset), .pc_out(pc_out),
        .wb_e(wb_e), .wb_a(wb_a), .wb_d(wb_d), .dump(dump), .done(done),
        .pass(pass), .err_idx(err_idx), .err_a(err_a), .err_d(err_d),
        .err_timeout(err_timeout), .cycle_count(cycle_count)
    );

    typedef struct {
        int                k;
        logic [REG_AW-1:0] a;
        logic [XLEN-1:0]   d;
    } wb_ev_t;

    typedef struct {
        bit                pass;
        int                idx;
        logic [REG_AW-1:0] a;
        logic [XLEN-1:0]   d;
        bit                tmo;
        int                ccount;
        int                dump_cnt;
        int                dump_k;
    } result_t;

    result_t   exp_q[$];
    wb_ev_t    ev_q[$];
    wb_entry_t model_tab[EXP_DEPTH];
    int        n_checks = 0;
    int        n_errors = 0;
    int        g_dump_cnt = 0;
    int        g_dump_k = -1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Outcome of a run: walk the writebacks the checker can see, in order,
    // against the first `count` table entries.
    function automatic result_t predict(input wb_ev_t evs[$], input int count,
                                        input logic [XLEN-1:0] hpc, input int base);
        result_t r;
        longint  h;
        int      last;
        int      ptr;
        bit      err;
        bit      bad;
        r.pass = 0; r.idx = 0; r.a = '0; r.d = '0; r.tmo = 0;
        r.ccount = 0; r.dump_cnt = 0; r.dump_k = -1;
        ptr = 0; err = 0;
        h = (longint'(base) >= longint'({32'd0, hpc})) ? 0 : longint'({32'd0, hpc}) - base;
        if (h < TIMEOUT) begin
            last       = int'(h) + DRAIN_CYCLES;
            r.ccount   = int'(h) + 1 + DRAIN_CYCLES;
            r.dump_cnt = 1;
            r.dump_k   = int'(h) + DRAIN_CYCLES + 1;
        end else begin
            last     = TIMEOUT - 1;
            r.ccount = TIMEOUT;
            r.tmo    = 1;
        end
        foreach (evs[i]) begin
            if (evs[i].k <= last && evs[i].a != 0) begin
                if (ptr >= count) bad = 1;
                else bad = (evs[i].a != model_tab[ptr].rd) || (evs[i].d != model_tab[ptr].data);
                if (bad && !err) begin
                    err = 1; r.idx = ptr; r.a = evs[i].a; r.d = evs[i].d;
                end
                if (ptr < EXP_DEPTH) ptr++;
            end
        end
        if (!err && ptr != count) begin
            err = 1; r.idx = ptr; r.a = '0; r.d = '0;
        end
        r.pass = !err && !r.tmo;
        return r;
    endfunction

    task automatic load_entry(input int idx, input logic [REG_AW-1:0] a,
                              input logic [XLEN-1:0] d, input bit track);
        @(negedge clk);
        exp_we = 1'b1; exp_waddr = idx[AW-1:0]; exp_a = a; exp_d = d;
        @(negedge clk);
        exp_we = 1'b0;
        if (track) model_tab[idx] = '{rd: a, data: d};
    endtask

    task automatic add_ev(input int k, input logic [REG_AW-1:0] a, input logic [XLEN-1:0] d);
        wb_ev_t e;
        e.k = k; e.a = a; e.d = d;
        ev_q.push_back(e);
    endtask

    // Issues start, then plays the CPU until done (or aborts with reset at
    // RUN-relative cycle abort_k). k counts cycles since dut_reset dropped.
    task automatic do_run(input logic [XLEN-1:0] hpc, input int base, input int cnt,
                          input int abort_k, input bit co_we, input int co_idx,
                          input logic [REG_AW-1:0] co_a, input logic [XLEN-1:0] co_d);
        int      k;
        int      rst_hi;
        int      cnt_eff;
        bit      fin;
        wb_ev_t  evq[$];
        wb_ev_t  ev;
        k = 0; rst_hi = 0; fin = 0;
        cnt_eff = (cnt > EXP_DEPTH) ? EXP_DEPTH : cnt;
        @(negedge clk);
        start = 1'b1; halt_pc = hpc; exp_count = cnt[AW:0];
        if (co_we) begin
            exp_we = 1'b1; exp_waddr = co_idx[AW-1:0]; exp_a = co_a; exp_d = co_d;
            model_tab[co_idx] = '{rd: co_a, data: co_d};
        end
        if (abort_k < 0) exp_q.push_back(predict(ev_q, cnt_eff, hpc, base));
        g_dump_cnt = 0; g_dump_k = -1;
        evq = ev_q;
        @(negedge clk);
        start = 1'b0; exp_we = 1'b0;
        for (int cyc = 0; cyc < 160 && !fin; cyc++) begin
            wb_e = 1'b0; wb_a = '0; wb_d = '0;
            if (dump) begin g_dump_cnt++; g_dump_k = k; end
            if (done) begin
                fin = 1;
            end else if (dut_reset) begin
                rst_hi++;
            end else begin
                if (abort_k >= 0 && k == abort_k) begin
                    reset = 1'b1;
                    @(negedge clk);
                    reset = 1'b0;
                    check("abort_dut_reset", dut_reset, 1);
                    check("abort_done", done, 0);
                    check("abort_dump", dump, 0);
                    check("abort_pass", pass, 0);
                    check("abort_cycle_count", cycle_count, 0);
                    check("abort_err_idx", err_idx, 0);
                    return;
                end
                pc_out = 32'(base + k);
                if (evq.size() > 0 && evq[0].k == k) begin
                    ev = evq.pop_front();
                    wb_e = 1'b1; wb_a = ev.a; wb_d = ev.d;
                end
                k++;
            end
            if (!fin) @(negedge clk);
        end
        if (!fin) begin
            n_checks++; n_errors++;
            $display("FAIL run_bound: done not seen, got 0, expected 1");
        end
        check("reset_hold_cycles", rst_hi, RESET_CYCLES);
    endtask

    // Scoreboard monitor: pops one prediction per rising edge of done.
    initial begin : monitor
        bit      prev;
        result_t e;
        prev = 0;
        forever begin
            @(negedge clk);
            if (done && !prev) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL unexpected_done: got 1, expected 0");
                end else begin
                    e = exp_q.pop_front();
                    check("pass", pass, e.pass);
                    check("err_idx", err_idx, e.idx);
                    check("err_a", err_a, e.a);
                    check("err_d", err_d, e.d);
                    check("err_timeout", err_timeout, e.tmo);
                    check("cycle_count", cycle_count, e.ccount);
                    check("dump_count", g_dump_cnt, e.dump_cnt);
                    check("dump_cycle", g_dump_k, e.dump_k);
                end
            end
            prev = done;
        end
    end

    initial begin : stimulus
        int h, base, cnt, cnt_eff, nev, k;
        logic [XLEN-1:0] d;
        reset = 1'b1; start = 1'b0; exp_we = 1'b0; wb_e = 1'b0;
        halt_pc = '0; exp_d = '0; pc_out = '0; wb_d = '0;
        exp_waddr = '0; exp_a = '0; wb_a = '0; exp_count = '0;
        repeat (3) @(negedge clk);
        check("rst_dut_reset", dut_reset, 1);
        check("rst_dump", dump, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err_idx", err_idx, 0);
        check("rst_err_a", err_a, 0);
        check("rst_err_d", err_d, 0);
        check("rst_err_timeout", err_timeout, 0);
        check("rst_cycle_count", cycle_count, 0);
        reset = 1'b0;

        for (int i = 0; i < EXP_DEPTH; i++)
            load_entry(i, 5'($urandom_range(1, 31)), $urandom, 1);
        load_entry(0, 5'd1, 32'hDEADBEEF, 1);
        load_entry(1, 5'd2, 32'h12345678, 1);
        load_entry(2, 5'd7, 32'h00000004, 1);

        // Golden run, last entry written in the same cycle as start.
        ev_q.delete();
        add_ev(1, 5'd1, 32'hDEADBEEF); add_ev(3, 5'd2, 32'h12345678);
        add_ev(5, 5'd7, 32'h4);        add_ev(7, 5'd3, 32'hFEDCBA98);
        do_run(32'd12, 2, 4, -1, 1, 3, 5'd3, 32'hFEDCBA98);

        // Data mismatch on the fourth, then an extra writeback.
        ev_q.delete();
        add_ev(1, 5'd1, 32'hDEADBEEF); add_ev(3, 5'd2, 32'h12345678);
        add_ev(5, 5'd7, 32'h4);        add_ev(7, 5'd3, 32'hFEDCBA99);
        add_ev(9, 5'd5, 32'h1);
        do_run(32'd12, 2, 4, -1, 0, 0, '0, '0);

        // x0 writes interleaved.
        ev_q.delete();
        add_ev(0, 5'd0, 32'h1);        add_ev(1, 5'd1, 32'hDEADBEEF);
        add_ev(2, 5'd0, 32'h5);        add_ev(3, 5'd2, 32'h12345678);
        add_ev(4, 5'd7, 32'h4);        add_ev(6, 5'd0, 32'h9);
        add_ev(7, 5'd3, 32'hFEDCBA98); add_ev(8, 5'd0, 32'h7);
        do_run(32'd12, 2, 4, -1, 0, 0, '0, '0);

        // Timeout: pc never reaches halt_pc.
        ev_q.delete();
        add_ev(1, 5'd1, 32'hDEADBEEF); add_ev(3, 5'd2, 32'h12345678);
        add_ev(5, 5'd7, 32'h4);        add_ev(7, 5'd3, 32'hFEDCBA98);
        do_run(32'hFFFFFFFF, 0, 4, -1, 0, 0, '0, '0);

        // Halt on the last RUN cycle beats the timeout.
        do_run(32'd49, 0, 4, -1, 0, 0, '0, '0);

        // Short count: three writebacks.
        ev_q.delete();
        add_ev(1, 5'd1, 32'hDEADBEEF); add_ev(3, 5'd2, 32'h12345678);
        add_ev(5, 5'd7, 32'h4);
        do_run(32'd12, 2, 4, -1, 0, 0, '0, '0);

        // Five writebacks against count 4.
        add_ev(7, 5'd3, 32'hFEDCBA98); add_ev(11, 5'd9, 32'hCAFE0001);
        do_run(32'd12, 2, 4, -1, 0, 0, '0, '0);

        // Reset during DRAIN, then rerun on the retained table.
        ev_q.delete();
        add_ev(1, 5'd1, 32'hDEADBEEF); add_ev(3, 5'd2, 32'h12345678);
        add_ev(5, 5'd7, 32'h4);        add_ev(7, 5'd3, 32'hFEDCBA98);
        do_run(32'd12, 2, 4, 12, 0, 0, '0, '0);
        do_run(32'd12, 2, 4, -1, 0, 0, '0, '0);

        // Table writes outside IDLE must be ignored.
        load_entry(0, 5'd9, 32'h11111111, 0);
        do_run(32'd12, 2, 4, -1, 0, 0, '0, '0);

        // Randomized runs.
        for (int it = 0; it < 24; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                @(negedge clk); reset = 1'b1;
                @(negedge clk); reset = 1'b0;
                for (int j = 0; j < 4; j++)
                    load_entry($urandom_range(0, EXP_DEPTH - 1), 5'($urandom_range(1, 31)), $urandom, 1);
            end
            cnt = $urandom_range(0, EXP_DEPTH + 3);
            cnt_eff = (cnt > EXP_DEPTH) ? EXP_DEPTH : cnt;
            h = $urandom_range(15, 45);
            if ($urandom_range(0, 7) == 0) h = TIMEOUT + 10;
            base = $urandom_range(0, 5);
            nev = cnt_eff + $urandom_range(0, 3) - 1;
            if (nev < 0) nev = 0;
            ev_q.delete();
            k = $urandom_range(0, 2);
            for (int j = 0; j < nev; j++) begin
                if ($urandom_range(0, 4) == 0) begin
                    add_ev(k, 5'd0, $urandom);
                    k++;
                end
                if (j < EXP_DEPTH) begin
                    d = model_tab[j].data;
                    if ($urandom_range(0, 9) == 0) d = d ^ (32'd1 << $urandom_range(0, 31));
                    add_ev(k, model_tab[j].rd, d);
                end else begin
                    add_ev(k, 5'($urandom_range(1, 31)), $urandom);
                end
                k += $urandom_range(1, 3);
            end
            do_run(32'(base + h), base, cnt, -1, 0, 0, '0, '0);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_rvp_wb_checker
`default_nettype wire
